halt_ctrl: RTL and testbench
============================

// Module: halt_ctrl
// PURPOSE
//  Core-side trap responder: accepts trap requests (ebreak, illegal opcode, ALU overflow, watchdog),
//  freezes the core, drains in-flight writebacks, then reports a single exit record to the sim
//  harness over a valid/ready handshake. Sits between the core's decode/execute and the top-level
//  testbench; the harness is the consumer of halt_* and ends simulation.
// PARAMETERS
//  DRAIN_CYCLES    4   cycles core_stall is held before reporting (0 = report next cycle)
//  CNT_W           32  width of cycle counter
//  TIMEOUT_CYCLES  0   watchdog limit in RUN cycles; 0 disables watchdog
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous, active-low
//  trap_valid  in   1      trap request this cycle
//  trap_cause  in   2      00 EBREAK, 01 ILLEGAL, 10 OVERFLOW (11 reserved, treated as ILLEGAL)
//  trap_pc     in   32     PC of trapping instruction
//  a0_value    in   32     current x10 value (exit code source for EBREAK)
//  core_stall  out  1      freeze fetch/commit
//  halt_valid  out  1      exit record valid
//  halt_ready  in   1      harness accepts record
//  halt_good   out  1      1 = GOOD trap
//  halt_code   out  32     exit code
//  halt_pc     out  32     latched trap PC
//  halt_cause  out  2      latched cause; 11 = TIMEOUT
//  halted      out  1      handshake completed, sticky until reset
//  cycle_count out  CNT_W  RUN cycles elapsed, saturating
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state RUN; all outputs 0; counters 0. Reset in any state aborts.
//  - States: RUN -> DRAIN -> REPORT -> HALTED. HALTED exits only via reset.
//  - RUN: cycle_count +1 per cycle, saturates at all-ones. trap_valid=1 latches cause/pc/code,
//    next state DRAIN (REPORT if DRAIN_CYCLES==0); core_stall=1 from the following cycle.
//  - Watchdog: TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 with no trap_valid -> latch
//    cause 11, pc=trap_pc, code=32'hFFFF_FFFF, good=0. trap_valid same cycle wins over timeout.
//  - Code rules: EBREAK -> code=a0_value, good=(a0_value==0). ILLEGAL/OVERFLOW -> code=1, good=0.
//  - trap_valid outside RUN ignored; latched fields never change after capture.
//  - DRAIN: down-counter loaded with DRAIN_CYCLES-1; core_stall=1; at 0 -> REPORT.
//  - REPORT: halt_valid=1, fields stable until halt_valid&&halt_ready; then HALTED next cycle,
//    halt_valid=0, halted=1, core_stall stays 1. halt_ready ignored outside REPORT.
//  - cycle_count frozen once state leaves RUN.
// CONFIGURATION
//  TRAP_DISPLAY_EN defined: on handshake cycle print banner (HIT GOOD/BAD TRAP, cause, PC, code)
//    then $finish(halt_good ? 0 : 1).
//  Undefined: no system tasks; block fully synthesizable, harness owns termination.
// STRUCTURE
//  - Shared package halt_pkg: cause encodings (CAUSE_EBREAK/ILLEGAL/OVERFLOW/TIMEOUT),
//    state encodings, EXIT_CODE_BAD/EXIT_CODE_TIMEOUT constants.
//  - One sub-module: sat_counter (parameterised width, enable, sync clear, saturate) for cycle_count.
//  - FSM + drain counter + capture registers stay in halt_ctrl.
// TESTING
//  1. ebreak, a0=0, pc=0x8000_0010, halt_ready=1, DRAIN=4 -> stall next cycle, halt_valid 4 cycles
//     later, good=1, code=0, pc=0x8000_0010, cause=00; halted=1 cycle after.
//  2. ebreak, a0=5 -> good=0, code=5; halt_ready held low 10 cycles -> fields/valid stable all 10.
//  3. overflow at pc=0x8000_0100, then ebreak 2 cycles later -> record stays cause=10, code=1.
//  4. TIMEOUT_CYCLES=100, no trap -> cause=11, code=0xFFFF_FFFF, cycle_count frozen at 100.
//  5. trap_valid on exact timeout cycle -> trap cause reported, not 11.
//  6. rst low during REPORT -> all outputs 0 next cycle, new ebreak afterwards completes normally.

Source files
------------

// File: rtl/halt_pkg.sv
// Shared encodings for the trap responder: trap causes, controller states and exit codes.
package halt_pkg;

    typedef enum logic [1:0] {
        CAUSE_EBREAK   = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_OVERFLOW = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_REPORT,
        ST_HALTED
    } state_t;

    localparam logic [31:0] EXIT_CODE_BAD     = 32'd1;
    localparam logic [31:0] EXIT_CODE_TIMEOUT = 32'hFFFF_FFFF;

    // The reserved request encoding 11 is reported as an illegal instruction;
    // TIMEOUT is only ever produced by the watchdog.
    function automatic cause_t decode_cause(input logic [1:0] raw);
        case (raw)
            2'b00:   decode_cause = CAUSE_EBREAK;
            2'b10:   decode_cause = CAUSE_OVERFLOW;
            default: decode_cause = CAUSE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/halt_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear (clear has priority).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/halt_ctrl.sv
// Trap responder: freezes the core, drains writebacks, then hands one exit record to the harness.
// Optional: define TRAP_DISPLAY_EN to print a trap banner and end simulation on the handshake.
module halt_ctrl
    import halt_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_valid,
    input  logic [1:0]       trap_cause,
    input  logic [31:0]      trap_pc,
    input  logic [31:0]      a0_value,
    output logic             core_stall,
    output logic             halt_valid,
    input  logic             halt_ready,
    output logic             halt_good,
    output logic [31:0]      halt_code,
    output logic [31:0]      halt_pc,
    output logic [1:0]       halt_cause,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES == 0) ? '0 : DW'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    cause_t          cause_q;
    cause_t          req_cause;
    logic            timeout_hit;

    assign req_cause   = decode_cause(trap_cause);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST);
    assign halt_cause  = cause_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .en    (state == ST_RUN),
        .clr   (!rst),
        .count (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_RUN;
            drain_cnt  <= '0;
            core_stall <= 1'b0;
            halt_valid <= 1'b0;
            halted     <= 1'b0;
            halt_good  <= 1'b0;
            halt_code  <= '0;
            halt_pc    <= '0;
            cause_q    <= CAUSE_EBREAK;
        end else begin
            case (state)
                ST_RUN: begin
                    if (trap_valid || timeout_hit) begin
                        halt_pc    <= trap_pc;
                        core_stall <= 1'b1;
                        // A real trap request wins over a watchdog expiry in the same cycle.
                        if (trap_valid) begin
                            cause_q <= req_cause;
                            if (req_cause == CAUSE_EBREAK) begin
                                halt_code <= a0_value;
                                halt_good <= (a0_value == '0);
                            end else begin
                                halt_code <= EXIT_CODE_BAD;
                                halt_good <= 1'b0;
                            end
                        end else begin
                            cause_q   <= CAUSE_TIMEOUT;
                            halt_code <= EXIT_CODE_TIMEOUT;
                            halt_good <= 1'b0;
                        end
                        if (DRAIN_CYCLES == 0) begin
                            state      <= ST_REPORT;
                            halt_valid <= 1'b1;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state      <= ST_REPORT;
                        halt_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (halt_ready) begin
                        state      <= ST_HALTED;
                        halt_valid <= 1'b0;
                        halted     <= 1'b1;
                    end
                end
                ST_HALTED: begin
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef TRAP_DISPLAY_EN
    always @(posedge clk) begin
        if (rst && (state == ST_REPORT) && halt_valid && halt_ready) begin
            $display("HIT %s TRAP: cause=%0d pc=%08h code=%08h",
                     halt_good ? "GOOD" : "BAD", halt_cause, halt_pc, halt_code);
            if (halt_good) $finish(0);
            else           $finish(1);
        end
    end
`endif

endmodule

// File: tb/tb_halt_ctrl.sv
// Self-checking bench for halt_ctrl: code-rule table, hand-written corner sequences and
// randomized traffic compared every cycle against an event-based reference model.
module tb_halt_ctrl;

    localparam int DRAIN = 4;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trap_valid = 1'b0;
    logic [1:0]  trap_cause = 2'b00;
    logic [31:0] trap_pc = '0;
    logic [31:0] a0_value = '0;
    logic        halt_ready = 1'b0;

    logic        core_stall, halt_valid, halt_good, halted;
    logic [31:0] halt_code, halt_pc, cycle_count;
    logic [1:0]  halt_cause;

    logic        s_stall, s_valid, s_good, s_halted;
    logic [31:0] s_code, s_pc;
    logic [1:0]  s_cause;
    logic [3:0]  s_count;

    int n_checks = 0;
    int n_err    = 0;

    halt_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .a0_value(a0_value), .core_stall(core_stall),
        .halt_valid(halt_valid), .halt_ready(halt_ready), .halt_good(halt_good),
        .halt_code(halt_code), .halt_pc(halt_pc), .halt_cause(halt_cause),
        .halted(halted), .cycle_count(cycle_count)
    );

    halt_ctrl #(.DRAIN_CYCLES(0), .CNT_W(4), .TIMEOUT_CYCLES(0)) dut_small (
        .clk(clk), .rst(rst), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .a0_value(a0_value), .core_stall(s_stall),
        .halt_valid(s_valid), .halt_ready(halt_ready), .halt_good(s_good),
        .halt_code(s_code), .halt_pc(s_pc), .halt_cause(s_cause),
        .halted(s_halted), .cycle_count(s_count)
    );

    always #5 clk = ~clk;

    // Reference model: tracks "captured?", edges since capture and "accepted?".
    bit          m_cap, m_done;
    int unsigned m_since;
    logic [31:0] m_run, m_code, m_pc;
    logic        m_good;
    logic [1:0]  m_cause;

    task automatic model_step();
        logic [31:0] prev;
        if (!rst) begin
            m_cap = 0; m_done = 0; m_since = 0; m_run = '0;
            m_code = '0; m_pc = '0; m_good = 0; m_cause = 2'd0;
        end else if (!m_cap) begin
            prev = m_run;
            if (m_run != 32'hFFFF_FFFF) m_run = m_run + 1;
            if (trap_valid) begin
                m_cap = 1; m_since = 0; m_pc = trap_pc;
                if (trap_cause == 2'd0) begin
                    m_cause = 2'd0; m_code = a0_value; m_good = (a0_value == 0);
                end else begin
                    m_cause = (trap_cause == 2'd2) ? 2'd2 : 2'd1;
                    m_code = 32'd1; m_good = 0;
                end
            end else if (prev == TMO - 1) begin
                m_cap = 1; m_since = 0; m_pc = trap_pc;
                m_cause = 2'd3; m_code = 32'hFFFF_FFFF; m_good = 0;
            end
        end else if (!m_done) begin
            if (m_since >= DRAIN && halt_ready) m_done = 1;
            else m_since = m_since + 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("core_stall",  core_stall,  m_cap);
        chk("halt_valid",  halt_valid,  m_cap && !m_done && (m_since >= DRAIN));
        chk("halted",      halted,      m_done);
        chk("halt_good",   halt_good,   m_good);
        chk("halt_code",   halt_code,   m_code);
        chk("halt_pc",     halt_pc,     m_pc);
        chk("halt_cause",  halt_cause,  m_cause);
        chk("cycle_count", cycle_count, m_run);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0; trap_valid = 1'b0; halt_ready = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        trap_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic trap(input logic [1:0] c, input logic [31:0] pc, input logic [31:0] a0);
        trap_valid = 1'b1; trap_cause = c; trap_pc = pc; a0_value = a0;
        cycle();
        trap_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int k = 0;
        while (!halt_valid && k < bound) begin
            cycle();
            k++;
        end
        chk(name, halt_valid, 1'b1);
    endtask

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] a0;
        logic [31:0] pc;
        logic        exp_good;
        logic [31:0] exp_code;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, 32'd0,          32'h8000_0000, 1'b1, 32'd0,          2'b00};
        vecs[1] = '{2'b00, 32'd5,          32'h8000_0004, 1'b0, 32'd5,          2'b00};
        vecs[2] = '{2'b01, 32'd0,          32'h8000_0008, 1'b0, 32'd1,          2'b01};
        vecs[3] = '{2'b10, 32'd9,          32'h8000_000C, 1'b0, 32'd1,          2'b10};
        vecs[4] = '{2'b11, 32'd0,          32'h8000_0010, 1'b0, 32'd1,          2'b01};
        vecs[5] = '{2'b00, 32'hFFFF_FFFF,  32'h8000_0014, 1'b0, 32'hFFFF_FFFF, 2'b00};

        do_reset();
        chk("reset_stall", core_stall, 1'b0);
        chk("reset_count", cycle_count, 32'd0);

        foreach (vecs[i]) begin
            do_reset();
            idle(2);
            trap(vecs[i].cause, vecs[i].pc, vecs[i].a0);
            wait_valid("vec_wait", 10);
            chk("vec_good",  halt_good,  vecs[i].exp_good);
            chk("vec_code",  halt_code,  vecs[i].exp_code);
            chk("vec_pc",    halt_pc,    vecs[i].pc);
            chk("vec_cause", halt_cause, vecs[i].exp_cause);
            halt_ready = 1'b1;
            cycle();
            chk("vec_halted", halted, 1'b1);
            halt_ready = 1'b0;
        end

        // Drain latency: stall the cycle after the trap, valid four cycles later.
        do_reset();
        halt_ready = 1'b1;
        trap(2'b00, 32'h8000_0010, 32'd0);
        chk("t1_stall", core_stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_not_valid", halt_valid, 1'b0);
        end
        cycle();
        chk("t1_valid", halt_valid, 1'b1);
        chk("t1_good",  halt_good,  1'b1);
        chk("t1_pc",    halt_pc,    32'h8000_0010);
        cycle();
        chk("t1_halted", halted, 1'b1);
        chk("t1_valid_drop", halt_valid, 1'b0);
        halt_ready = 1'b0;

        // Back-pressure: record held stable while the harness stalls.
        do_reset();
        trap(2'b00, 32'h8000_0020, 32'd5);
        wait_valid("t2_wait", 10);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t2_valid_hold", halt_valid, 1'b1);
            chk("t2_code_hold",  halt_code,  32'd5);
        end
        halt_ready = 1'b1;
        cycle();
        chk("t2_halted", halted, 1'b1);
        halt_ready = 1'b0;

        // Second trap while draining is ignored.
        do_reset();
        trap(2'b10, 32'h8000_0100, 32'd7);
        idle(1);
        trap(2'b00, 32'h8000_0200, 32'd0);
        wait_valid("t3_wait", 10);
        chk("t3_cause", halt_cause, 2'b10);
        chk("t3_code",  halt_code,  32'd1);
        chk("t3_pc",    halt_pc,    32'h8000_0100);

        // Watchdog expiry.
        do_reset();
        trap_pc = 32'h0000_1234;
        idle(TMO);
        chk("t4_stall", core_stall, 1'b1);
        wait_valid("t4_wait", 10);
        chk("t4_cause", halt_cause, 2'b11);
        chk("t4_code",  halt_code,  32'hFFFF_FFFF);
        chk("t4_count", cycle_count, 32'd100);

        // Trap on the exact expiry cycle wins.
        do_reset();
        idle(TMO - 1);
        trap(2'b01, 32'h0000_0ABC, 32'd0);
        wait_valid("t5_wait", 10);
        chk("t5_cause", halt_cause, 2'b01);
        chk("t5_count", cycle_count, 32'd100);

        // Reset in REPORT, then a clean run.
        do_reset();
        trap(2'b00, 32'h8000_0300, 32'd3);
        wait_valid("t6_wait", 10);
        rst = 1'b0;
        cycle();
        chk("t6_valid", halt_valid, 1'b0);
        chk("t6_code",  halt_code,  32'd0);
        chk("t6_stall", core_stall, 1'b0);
        rst = 1'b1;
        halt_ready = 1'b1;
        trap(2'b00, 32'h8000_0400, 32'd0);
        wait_valid("t6_wait2", 10);
        cycle();
        chk("t6_halted", halted, 1'b1);
        chk("t6_good",   halt_good, 1'b1);
        halt_ready = 1'b0;

        // Narrow counter saturates; zero drain reports with the stall.
        do_reset();
        idle(20);
        chk("s_count_sat", s_count, 4'hF);
        trap(2'b00, 32'h0000_0040, 32'd0);
        chk("s_valid",      s_valid, 1'b1);
        chk("s_stall",      s_stall, 1'b1);
        chk("s_good",       s_good,  1'b1);
        chk("s_count_hold", s_count, 4'hF);
        halt_ready = 1'b1;
        cycle();
        chk("s_halted", s_halted, 1'b1);
        chk("s_valid_drop", s_valid, 1'b0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) != 0);
            trap_valid = ($urandom_range(0, 29) == 0);
            trap_cause = 2'($urandom_range(0, 3));
            a0_value   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            trap_pc    = $urandom;
            halt_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
